// File: rtl/irq_request_latch_pkg.sv
// Shared constants for the interrupt request path feeding priority_encoder_83.
package irq_pkg;
  localparam int unsigned IRQ_N     = 8;
  localparam int unsigned IRQ_IDX_W = 3;
  localparam bit          EDGE      = 1'b1;
  localparam bit          LEVEL     = 1'b0;
endpackage

// File: rtl/irq_request_latch_edge_detect.sv
// Per-line event generation: rising edges of req_in (edge mode) or the raw level.
module irq_edge_detect
  import irq_pkg::*;
#(
  parameter int unsigned N         = IRQ_N,
  parameter bit          EDGE_MODE = EDGE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] set_vec
);

  logic [N-1:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req_in;
  end

  // Level mode ignores the history register entirely.
  assign set_vec = req_in & ~(req_q & {N{EDGE_MODE}});

endmodule

// File: rtl/irq_request_latch.sv
// Sticky pending/overflow bits per request line, masked view for the priority encoder.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int unsigned N         = IRQ_N,
  parameter int unsigned IDX_W     = IRQ_IDX_W,
  parameter bit          EDGE_MODE = EDGE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N-1:0]     pending,
  output logic             irq,
  output logic [N-1:0]     overflow
);

  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pend_q;
  logic [N-1:0] ovf_q;

  irq_edge_detect #(
    .N         (N),
    .EDGE_MODE (EDGE_MODE)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .set_vec (set_vec)
  );

  // Out-of-range indices decode to nothing.
  always_comb begin
    clr_vec = '0;
    if (ack && (32'(ack_idx) < N)) clr_vec = N'(1) << ack_idx;
  end

  // Set wins over clear for pend; a new overflow event wins over ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_vec) | set_vec;
      ovf_q  <= (ovf_clr ? '0 : ovf_q) | (set_vec & pend_q & ~clr_vec);
    end
  end

  assign pending  = pend_q & mask;
  assign irq      = |pending;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Randomized and directed checks of irq_request_latch against a per-line behavioural model.
module tb_irq_request_latch;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;

  logic [7:0] pend_a, ovf_a, pend_b, ovf_b;
  logic [5:0] pend_c, ovf_c;
  logic       irq_a, irq_b, irq_c;

  int total = 0;
  int bad   = 0;

  // model state: 0 = N8 edge, 1 = N8 level, 2 = N6 edge
  logic [7:0]  m_pend [3];
  logic [7:0]  m_ovf  [3];
  logic [7:0]  m_prev [3];
  int unsigned m_n    [3];
  bit          m_edge [3];

  irq_request_latch #(.N(8), .IDX_W(3), .EDGE_MODE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_in(req), .mask(mask), .ack(ack), .ack_idx(ack_idx),
    .ovf_clr(ovf_clr), .pending(pend_a), .irq(irq_a), .overflow(ovf_a));

  irq_request_latch #(.N(8), .IDX_W(3), .EDGE_MODE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_in(req), .mask(mask), .ack(ack), .ack_idx(ack_idx),
    .ovf_clr(ovf_clr), .pending(pend_b), .irq(irq_b), .overflow(ovf_b));

  irq_request_latch #(.N(6), .IDX_W(3), .EDGE_MODE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_in(req[5:0]), .mask(mask[5:0]), .ack(ack), .ack_idx(ack_idx),
    .ovf_clr(ovf_clr), .pending(pend_c), .irq(irq_c), .overflow(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and apply the request-line rules to every model.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_pend[d] = '0;
        m_ovf[d]  = '0;
        m_prev[d] = '0;
      end else begin
        for (int i = 0; i < int'(m_n[d]); i++) begin
          bit ev, cl, was;
          ev  = m_edge[d] ? (req[i] && !m_prev[d][i]) : req[i];
          cl  = ack && (int'(ack_idx) == i);
          was = m_pend[d][i];
          m_ovf[d][i]  = (ovf_clr ? 1'b0 : m_ovf[d][i]) | (ev && was && !cl);
          m_pend[d][i] = ev || (was && !cl);
        end
        m_prev[d] = req;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    req = '0; mask = 8'hFF; ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int hi_idx(logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    req = 8'hFF; mask = 8'hFF; ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    total++; if (pend_a !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h want=00", pend_a); end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_a); end
    total++; if (ovf_a !== 8'h00) begin bad++; $display("FAIL reset_overflow got=%h want=00", ovf_a); end
    rst = 1'b0;
    tick();
    total++; if (pend_a !== 8'hFF) begin bad++; $display("FAIL release_pending_a got=%h want=ff", pend_a); end
    total++; if (pend_b !== 8'hFF) begin bad++; $display("FAIL release_pending_b got=%h want=ff", pend_b); end
    total++; if (pend_c !== 6'h3F) begin bad++; $display("FAIL release_pending_c got=%h want=3f", pend_c); end
  endtask

  task automatic test_edge_capture();
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (pend_a !== 8'h04) begin bad++; $display("FAIL edge_hold_%0d got=%h want=04", k, pend_a); end
    end
    total++; if (ovf_a !== 8'h00) begin bad++; $display("FAIL edge_no_ovf got=%h want=00", ovf_a); end
    ack = 1'b1; ack_idx = 3'd2;
    tick();
    ack = 1'b0;
    total++; if (pend_a !== 8'h00 || irq_a !== 1'b0) begin
      bad++; $display("FAIL edge_ack got=%h/%b want=00/0", pend_a, irq_a); end
  endtask

  task automatic test_collision();
    do_reset();
    req = 8'h08; tick();
    req = 8'h00; tick();
    req = 8'h08; ack = 1'b1; ack_idx = 3'd3;
    tick();
    ack = 1'b0;
    total++; if (pend_a[3] !== 1'b1) begin bad++; $display("FAIL collide_pend got=%b want=1", pend_a[3]); end
    total++; if (ovf_a[3] !== 1'b0) begin bad++; $display("FAIL collide_ovf got=%b want=0", ovf_a[3]); end
  endtask

  task automatic test_overflow();
    do_reset();
    req = 8'h20; tick();
    req = 8'h00; tick();
    req = 8'h20; tick();
    total++; if (ovf_a !== 8'h20) begin bad++; $display("FAIL ovf_set got=%h want=20", ovf_a); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++; if (ovf_a !== 8'h00) begin bad++; $display("FAIL ovf_clr got=%h want=00", ovf_a); end
    req = 8'h00; tick();
    req = 8'h20; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    total++; if (ovf_a !== 8'h20) begin bad++; $display("FAIL ovf_set_beats_clr got=%h want=20", ovf_a); end
  endtask

  task automatic test_mask();
    do_reset();
    mask = 8'h01; req = 8'h81;
    tick();
    total++; if (pend_a !== 8'h01 || irq_a !== 1'b1) begin
      bad++; $display("FAIL mask_hide got=%h/%b want=01/1", pend_a, irq_a); end
    ack = 1'b1; ack_idx = 3'd0;
    tick();
    ack = 1'b0;
    total++; if (pend_a !== 8'h00 || irq_a !== 1'b0) begin
      bad++; $display("FAIL mask_ack got=%h/%b want=00/0", pend_a, irq_a); end
    mask = 8'hFF;
    #1;
    total++; if (pend_a !== 8'h80 || irq_a !== 1'b1) begin
      bad++; $display("FAIL mask_expose got=%h/%b want=80/1", pend_a, irq_a); end
  endtask

  task automatic test_encoder_chain();
    int y;
    do_reset();
    req = 8'hFF; tick(); req = 8'h00;
    for (int k = 0; k < 8; k++) begin
      y = hi_idx(pend_a);
      total++; if (y != 7 - k) begin bad++; $display("FAIL chain_y_%0d got=%0d want=%0d", k, y, 7 - k); end
      ack = 1'b1; ack_idx = 3'(y);
      tick();
      ack = 1'b0;
    end
    total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL chain_done_irq got=%b want=0", irq_a); end
    do_reset();
    req = 8'h3F; tick(); req = 8'h00;
    ack = 1'b1; ack_idx = 3'd7; tick(); ack = 1'b0;
    total++; if (pend_c !== 6'h3F) begin bad++; $display("FAIL range_n6 got=%h want=3f", pend_c); end
    do_reset();
    req = 8'h01; tick();
    ack = 1'b1; ack_idx = 3'd0; tick(); ack = 1'b0;
    total++; if (pend_b !== 8'h01) begin bad++; $display("FAIL level_reset got=%h want=01", pend_b); end
    total++; if (pend_a !== 8'h00) begin bad++; $display("FAIL edge_no_reset got=%h want=00", pend_a); end
  endtask

  task automatic test_random();
    logic [7:0] ap, ao, ep, eo;
    logic       ai, ei;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req     = 8'($urandom);
      mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ack     = ($urandom_range(0, 1) == 1);
      ack_idx = 3'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        case (d)
          0:       begin ap = pend_a; ao = ovf_a; ai = irq_a; end
          1:       begin ap = pend_b; ao = ovf_b; ai = irq_b; end
          default: begin ap = {2'b00, pend_c}; ao = {2'b00, ovf_c}; ai = irq_c; end
        endcase
        ep = m_pend[d] & mask;
        eo = m_ovf[d];
        ei = |ep;
        total++;
        if (ap !== ep || ao !== eo || ai !== ei) begin
          bad++;
          $display("FAIL rand_c%0d_d%0d pend=%h ovf=%h irq=%b want pend=%h ovf=%h irq=%b",
                   c, d, ap, ao, ai, ep, eo, ei);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_n[0] = 8; m_n[1] = 8; m_n[2] = 6;
    m_edge[0] = 1'b1; m_edge[1] = 1'b0; m_edge[2] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = '0; m_ovf[d] = '0; m_prev[d] = '0;
    end
    rst = 1'b1; req = '0; mask = 8'hFF; ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    test_reset();
    test_edge_capture();
    test_collision();
    test_overflow();
    test_mask();
    test_encoder_chain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
